// File: rtl/store_merge_unit_pkg.sv
// Shared encodings for the store path: store op codes, FSM states and
// small decode helpers used by the store merge unit and its lane merger.
package store_merge_unit_pkg;

  // Store op encodings, kept distinct from each other; any other value
  // is handled as a word store.
  localparam logic [2:0] STORE_BYTE = 3'd0;
  localparam logic [2:0] STORE_HALF = 3'd1;
  localparam logic [2:0] STORE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Sub-word stores need a read-modify-write; everything else writes directly.
  function automatic logic is_subword(input logic [2:0] op);
    return (op == STORE_BYTE) || (op == STORE_HALF);
  endfunction

  // A halfword on an odd byte, or a word off a word boundary, is misaligned.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
    if (op == STORE_BYTE) return 1'b0;
    if (op == STORE_HALF) return lo[0];
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merger: folds a byte or halfword of store data into
// the old memory word using little-endian lanes (lane k = bits 8k+7:8k).
module store_lane_merge
  import store_merge_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] old_word,
  input  logic [15:0] wdata_lo,
  output logic [31:0] merged
);

  // Replace the addressed lane(s); a halfword ignores lane[0].
  always_comb begin
    merged = old_word;
    case (op)
      STORE_BYTE: begin
        case (lane)
          2'd0:    merged[7:0]   = wdata_lo[7:0];
          2'd1:    merged[15:8]  = wdata_lo[7:0];
          2'd2:    merged[23:16] = wdata_lo[7:0];
          default: merged[31:24] = wdata_lo[7:0];
        endcase
      end
      STORE_HALF: begin
        if (lane[1]) merged[31:16] = wdata_lo;
        else         merged[15:0]  = wdata_lo;
      end
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store merge unit: performs SB/SH/SW to a word-wide memory without byte
// enables. Sub-word stores read the word, merge the new lane(s) and write
// it back; word stores write directly. A one-cycle done pulse ends each
// request.
// Optional build macro: STORE_ALIGN_CHECK_EN adds the misalign output and
// completes misaligned SH/SW requests without touching memory.
//
// Memory handshake: mem_rd or mem_wr (never both) is a request held high,
// with mem_addr and mem_wdata stable, until a cycle in which mem_ready is
// high; that cycle completes the request (and carries mem_rdata for reads).
module store_merge_unit
  import store_merge_unit_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready
`ifdef STORE_ALIGN_CHECK_EN
  ,
  output logic          misalign
`endif
);

  state_t      state;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic [31:0] merged;

  store_lane_merge u_merge (
    .op       (op_q),
    .lane     (lane_q),
    .old_word (mem_rdata),
    .wdata_lo (wdata_q),
    .merged   (merged)
  );

  // Store FSM with all memory-side outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      op_q      <= STORE_WORD;
      lane_q    <= 2'b00;
      wdata_q   <= '0;
`ifdef STORE_ALIGN_CHECK_EN
      misalign  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
      misalign <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q     <= op;
            lane_q   <= addr[1:0];
            wdata_q  <= wdata[15:0];
            mem_addr <= {addr[AW-1:2], 2'b00};
`ifdef STORE_ALIGN_CHECK_EN
            if (is_misaligned(op, addr[1:0])) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              misalign <= 1'b1;
            end else
`endif
            if (is_subword(op)) begin
              state  <= ST_READ;
              busy   <= 1'b1;
              mem_rd <= 1'b1;
            end else begin
              state     <= ST_WRITE;
              busy      <= 1'b1;
              mem_wr    <= 1'b1;
              mem_wdata <= wdata;
            end
          end
        end
        ST_READ: begin
          if (mem_ready) begin
            state     <= ST_WRITE;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b1;
            mem_wdata <= merged;
          end
        end
        ST_WRITE: begin
          if (mem_ready) begin
            state  <= ST_DONE;
            mem_wr <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Testbench for store_merge_unit: directed cases plus randomized stores
// with random memory wait states, checked against a byte-array model.
module tb_store_merge_unit;
  import store_merge_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
`ifdef STORE_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  store_merge_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready)
`ifdef STORE_ALIGN_CHECK_EN
    ,
    .misalign  (misalign)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: treat the old word as four bytes and overwrite the stored ones.
  function automatic logic [31:0] model_merge(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] old, input logic [31:0] d);
    logic [7:0] b[4];
    int base;
    for (int k = 0; k < 4; k++) b[k] = old[8*k +: 8];
    if (o == STORE_BYTE) begin
      b[a % 4] = d[7:0];
    end else if (o == STORE_HALF) begin
      base = ((a % 4) / 2) * 2;
      b[base]     = d[7:0];
      b[base + 1] = d[15:8];
    end else begin
      return d;
    end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Driver + memory responder for one store; checks timing and handshake rules.
  task automatic run_store(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] word, input int rw, input int ww, input bit poke);
    bit sub, mis, prev_rd, prev_wr;
    int cyc, rcnt, wcnt, rd_first, wr_first, done_cyc, viol, busy_bad, exp_done, exp_wr, exp_rd;
    logic [31:0] prev_a, prev_d, exp_w;
    sub = (o == STORE_BYTE) || (o == STORE_HALF);
    mis = 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
    mis = ((o == STORE_HALF) && a[0]) || (!sub && (a[1:0] != 2'b00));
`endif
    if (!mis) exp_q.push_back(model_merge(o, a, word, d));
    if (mis)      begin exp_done = 1;            exp_wr = -1;     exp_rd = -1; end
    else if (sub) begin exp_done = 3 + rw + ww;  exp_wr = 2 + rw; exp_rd = 1;  end
    else          begin exp_done = 2 + ww;       exp_wr = 1;      exp_rd = -1; end
    rd_first = -1; wr_first = -1; done_cyc = -1; viol = 0; busy_bad = 0;
    rcnt = 0; wcnt = 0; prev_rd = 0; prev_wr = 0; prev_a = '0; prev_d = '0;

    @(negedge clk);
    start = 1'b1; op = o; addr = a; wdata = d; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    start = poke; op = 3'($urandom); addr = $urandom; wdata = $urandom;
    cyc = 0;
    while (done_cyc < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) start = 1'b0;
      if (mem_rd && mem_wr) viol++;
      if (!done && !busy) busy_bad++;
      if (done && busy) busy_bad++;
      if ((prev_rd && mem_rd) || (prev_wr && mem_wr)) begin
        if (mem_addr !== prev_a) viol++;
        if (mem_wr && mem_wdata !== prev_d) viol++;
      end
      prev_rd = mem_rd; prev_wr = mem_wr; prev_a = mem_addr; prev_d = mem_wdata;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (mem_rd) begin
        if (rd_first < 0) rd_first = cyc;
        mem_ready = (rcnt >= rw);
        rcnt++;
        if (mem_ready) begin
          mem_rdata = word;
          check_eq("rd_addr", mem_addr, {a[31:2], 2'b00});
        end
      end
      if (mem_wr) begin
        if (wr_first < 0) wr_first = cyc;
        mem_ready = (wcnt >= ww);
        wcnt++;
        if (mem_ready) begin
          check_eq("wr_addr", mem_addr, {a[31:2], 2'b00});
          exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : ~mem_wdata;
          check_eq("wr_data", mem_wdata, exp_w);
        end
      end
      if (done) begin
        done_cyc = cyc;
`ifdef STORE_ALIGN_CHECK_EN
        check_eq("misalign", {31'b0, misalign}, {31'b0, mis});
`endif
      end
    end
    start = 1'b0;
    mem_ready = 1'b0;
    if (done_cyc < 0) check_eq("timeout", 32'd0, 32'd1);
    check_eq("done_cycle", done_cyc, exp_done);
    check_eq("wr_cycle", wr_first, exp_wr);
    check_eq("rd_cycle", rd_first, exp_rd);
    check_eq("handshake", viol, 0);
    check_eq("busy", busy_bad, 0);
    check_eq("write_pending", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check_eq("post_idle", {30'b0, done, busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {28'b0, busy, done, mem_rd, mem_wr}, 32'd0);
    check_eq({tag, "_addr"}, mem_addr, 32'd0);
    check_eq({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    int r, seen_done;
    logic [2:0] o;
    rst = 1'b1; start = 1'b0; op = STORE_WORD; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // directed cases
    run_store(STORE_WORD, 32'h100, 32'hDEADBEEF, 32'h0,       0, 0, 0);
    run_store(STORE_BYTE, 32'h203, 32'h000000AB, 32'h11223344, 0, 0, 0);
    run_store(STORE_HALF, 32'h302, 32'h0000CAFE, 32'h11223344, 0, 0, 0);
    run_store(STORE_HALF, 32'h300, 32'h0000CAFE, 32'h11223344, 0, 0, 0);
    run_store(STORE_BYTE, 32'h601, 32'h000000AB, 32'h11223344, 3, 2, 1);
    run_store(3'd7,       32'h703, 32'h01234567, 32'hFFFFFFFF, 1, 1, 0);

    // randomized stores with random wait states
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 7);
      o = (r < 3) ? STORE_BYTE : (r < 6) ? STORE_HALF : (r == 6) ? STORE_WORD : 3'($urandom_range(3, 7));
      run_store(o, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
    end

    // reset during the write phase of a byte store
    @(negedge clk);
    start = 1'b1; op = STORE_BYTE; addr = 32'h500; wdata = 32'h77; mem_ready = 1'b1;
    mem_rdata = 32'h55667788;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_in_write", {31'b0, mem_wr}, 32'd1);
    mem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("mid_reset");
    seen_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || mem_wr || mem_rd) seen_done++;
    end
    check_eq("no_done_after_rst", seen_done, 0);
    run_store(STORE_WORD, 32'h800, 32'hA5A55A5A, 32'h0, 0, 1, 0);

`ifdef STORE_ALIGN_CHECK_EN
    run_store(STORE_HALF, 32'h401, 32'h0000BEEF, 32'h11223344, 0, 0, 0);
    run_store(STORE_WORD, 32'h404, 32'h12345678, 32'h0,       0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
